// File: rtl/crc16_pkg.sv
// Shared CRC-16 definitions (x^16+x^15+x^2+1) used by both the serial
// generator and the serial checker.
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h8005;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CRC  = 2'd2
  } crc_state_t;

  // One MSB-first shift of the LFSR; the feedback taps follow CRC16_POLY.
  function automatic logic [15:0] crc16_step(input logic [15:0] lfsr, input logic din);
    logic fb;
    fb = lfsr[15] ^ din;
    return {lfsr[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_lfsr.sv
// CRC-16 LFSR register with synchronous preset and a per-bit step enable.
// Also exposes the look-ahead value so callers can capture the updated state.
module crc16_lfsr
  import crc16_pkg::*;
#(
  parameter logic [15:0] INIT = CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic        din,
  output logic [15:0] lfsr,
  output logic [15:0] lfsr_next
);

  logic [15:0] lfsr_reg;

  assign lfsr_next = crc16_step(lfsr_reg, din);
  assign lfsr      = lfsr_reg;

  // load outranks step so a restart never mixes in a bit from the old frame
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= INIT;
    end else if (load) begin
      lfsr_reg <= INIT;
    end else if (step) begin
      lfsr_reg <= lfsr_next;
    end
  end

endmodule

// File: rtl/crc_16_checker.sv
// Serial CRC-16 checker: recomputes the CRC over DATA_BITS message bits,
// then runs the 16 received CRC bits through the same LFSR and tests for zero residue.
module crc_16_checker
  import crc16_pkg::*;
#(
  parameter int          DATA_BITS = 24,
  parameter logic [15:0] INIT      = CRC16_INIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        din,
  input  logic        din_valid,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic [15:0] calc_crc,
  output logic [15:0] rx_crc,
  output logic [15:0] bit_cnt
);

  localparam logic [15:0] LAST_DATA = 16'(DATA_BITS - 1);
  localparam logic [15:0] LAST_CRC  = 16'd15;

  crc_state_t  state_reg, state_next;
  logic [15:0] bit_cnt_reg, bit_cnt_next;
  logic [15:0] rx_crc_reg, rx_crc_next;
  logic [15:0] calc_crc_reg, calc_crc_next;
  logic        crc_ok_reg, crc_ok_next;
  logic        done_reg, done_next;
  logic        lfsr_load, lfsr_step;
  logic [15:0] lfsr_cur, lfsr_upd;

  crc16_lfsr #(.INIT(INIT)) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load),
    .step      (lfsr_step),
    .din       (din),
    .lfsr      (lfsr_cur),
    .lfsr_next (lfsr_upd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= 16'd0;
      rx_crc_reg   <= 16'd0;
      calc_crc_reg <= 16'd0;
      crc_ok_reg   <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      rx_crc_reg   <= rx_crc_next;
      calc_crc_reg <= calc_crc_next;
      crc_ok_reg   <= crc_ok_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    rx_crc_next   = rx_crc_reg;
    calc_crc_next = calc_crc_reg;
    crc_ok_next   = crc_ok_reg;
    done_next     = 1'b0;
    lfsr_load     = 1'b0;
    lfsr_step     = 1'b0;

    // start has priority in every state, including over a completing CRC bit
    if (start) begin
      state_next   = DATA;
      lfsr_load    = 1'b1;
      bit_cnt_next = 16'd0;
      rx_crc_next  = 16'd0;
      crc_ok_next  = 1'b0;
    end else begin
      case (state_reg)
        DATA: begin
          if (din_valid) begin
            lfsr_step = 1'b1;
            if (bit_cnt_reg == LAST_DATA) begin
              calc_crc_next = lfsr_upd;
              bit_cnt_next  = 16'd0;
              state_next    = CRC;
            end else begin
              bit_cnt_next = bit_cnt_reg + 16'd1;
            end
          end
        end
        CRC: begin
          if (din_valid) begin
            lfsr_step    = 1'b1;
            rx_crc_next  = {rx_crc_reg[14:0], din};
            bit_cnt_next = bit_cnt_reg + 16'd1;
            if (bit_cnt_reg == LAST_CRC) begin
              done_next   = 1'b1;
              crc_ok_next = (lfsr_upd == 16'h0000);
              state_next  = IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_reg != IDLE);
  assign done     = done_reg;
  assign crc_ok   = crc_ok_reg;
  assign calc_crc = calc_crc_reg;
  assign rx_crc   = rx_crc_reg;
  assign bit_cnt  = bit_cnt_reg;

endmodule

// File: tb/tb_crc_16_checker.sv
// Scoreboard bench for crc_16_checker: three instances (DATA_BITS 1, 2, 24)
// driven by directed frames; a negedge monitor pops expected results on each done.
module tb_crc_16_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        start_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        ok_v    [3];
  logic [15:0] calc_v  [3];
  logic [15:0] rx_v    [3];
  logic [15:0] cnt_v   [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    crc_16_checker #(
      .DATA_BITS ((gi == 0) ? 1 : ((gi == 1) ? 2 : 24)),
      .INIT      (16'hFFFF)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start_v[gi]),
      .din       (din),
      .din_valid (din_valid),
      .busy      (busy_v[gi]),
      .done      (done_v[gi]),
      .crc_ok    (ok_v[gi]),
      .calc_crc  (calc_v[gi]),
      .rx_crc    (rx_v[gi]),
      .bit_cnt   (cnt_v[gi])
    );
  end

  typedef struct {
    int          inst;
    logic        ok;
    logic [15:0] calc;
    logic [15:0] rx;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   done_cnt  [3] = '{0, 0, 0};
  int   done_cyc  [3] = '{0, 0, 0};
  logic prev_done [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // Monitor: every done pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (done_v[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
        chk("done_one_cycle", int'(prev_done[k]), 0);
        chk("busy_fall_at_done", int'(busy_v[k]), 0);
        chk("ok_equals_rx_eq_calc", int'(ok_v[k]), int'(rx_v[k] == calc_v[k]));
        chk("done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("done_inst", k, e.inst);
          chk("crc_ok", int'(ok_v[k]), int'(e.ok));
          chk("calc_crc", int'(calc_v[k]), int'(e.calc));
          chk("rx_crc", int'(rx_v[k]), int'(e.rx));
          $display("frame inst=%0d ok=%0b calc=%04h rx=%04h cycle=%0d",
                   k, ok_v[k], calc_v[k], rx_v[k], cyc);
        end
      end
      prev_done[k] = done_v[k];
    end
  end

  // Bit-serial reference of the LFSR written directly from its tap equations.
  function automatic logic [15:0] model_crc(input logic [23:0] msg, input int db);
    logic [15:0] r;
    logic [15:0] n;
    logic        fb;
    r = 16'hFFFF;
    for (int i = db - 1; i >= 0; i--) begin
      fb    = r[15] ^ msg[i];
      n     = {r[14:0], fb};
      n[2]  = r[1] ^ fb;
      n[15] = r[14] ^ fb;
      r     = n;
    end
    return r;
  endfunction

  task automatic step(input int k, input logic st, input logic v, input logic b);
    for (int i = 0; i < 3; i++) start_v[i] = (i == k) ? st : 1'b0;
    din_valid = v;
    din       = b;
    @(negedge clk);
  endtask

  task automatic send_bit(input int k, input logic b, input int gaps_on, inout int gtot);
    int g;
    if (gaps_on != 0 && $urandom_range(0, 3) == 0) begin
      g = int'($urandom_range(1, 5));
      gtot += g;
      repeat (g) step(k, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    end
    step(k, 1'b0, 1'b1, b);
  endtask

  task automatic run_frame(input int k, input int db, input logic [23:0] msg,
                           input logic [15:0] crcf, input logic ok_e,
                           input logic [15:0] calc_e, input int gaps_on,
                           input logic do_start, output int lat, output int gtot);
    exp_t e;
    int   s_cyc;
    int   d0;
    e.inst = k; e.ok = ok_e; e.calc = calc_e; e.rx = crcf;
    exp_q.push_back(e);
    gtot  = 0;
    d0    = done_cnt[k];
    s_cyc = cyc;
    if (do_start) begin
      step(k, 1'b1, 1'b0, 1'b1);
      chk("busy_rise", int'(busy_v[k]), 1);
    end
    for (int i = db - 1; i >= 0; i--) send_bit(k, msg[i], gaps_on, gtot);
    for (int i = 15; i >= 0; i--) send_bit(k, crcf[i], gaps_on, gtot);
    repeat (3) step(-1, 1'b0, 1'b0, 1'b0);
    chk("done_count", done_cnt[k] - d0, 1);
    lat = done_cyc[k] - s_cyc;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] msg;
    logic [15:0] c;
    int lat, lat0, gt, d0;

    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    step(-1, 1'b0, 1'b0, 1'b0);
    chk("reset_busy", int'(busy_v[2]), 0);
    chk("reset_done", int'(done_v[2]), 0);
    chk("reset_crc_ok", int'(ok_v[2]), 0);
    chk("reset_calc", int'(calc_v[2]), 0);
    chk("reset_rx", int'(rx_v[2]), 0);
    chk("reset_bit_cnt", int'(cnt_v[2]), 0);

    // DATA_BITS=1: single 0 bit gives 16'h7FFB
    run_frame(0, 1, 24'h0, 16'h7FFB, 1'b1, 16'h7FFB, 0, 1'b1, lat, gt);
    chk("latency_db1", lat, 18);

    // DATA_BITS=2: message 1,0 gives 16'h7FF9; then bit 7 flipped
    run_frame(1, 2, 24'h2, 16'h7FF9, 1'b1, 16'h7FF9, 0, 1'b1, lat, gt);
    chk("latency_db2", lat, 19);
    run_frame(1, 2, 24'h2, 16'h7F79, 1'b0, 16'h7FF9, 0, 1'b1, lat, gt);
    run_frame(1, 2, 24'h2, 16'h7FF9, 1'b1, 16'h7FF9, 0, 1'b1, lat, gt);

    // Collision: start on the edge of the 16th CRC bit
    d0 = done_cnt[1];
    step(1, 1'b1, 1'b0, 1'b0);
    step(1, 1'b0, 1'b1, 1'b1);
    step(1, 1'b0, 1'b1, 1'b0);
    c = 16'h7FF9;
    for (int i = 15; i >= 1; i--) step(1, 1'b0, 1'b1, c[i]);
    step(1, 1'b1, 1'b1, c[0]);
    chk("collision_done", int'(done_v[1]), 0);
    chk("collision_busy", int'(busy_v[1]), 1);
    chk("collision_bit_cnt", int'(cnt_v[1]), 0);
    chk("collision_crc_ok", int'(ok_v[1]), 0);
    run_frame(1, 2, 24'h2, 16'h7FF9, 1'b1, 16'h7FF9, 0, 1'b0, lat, gt);
    chk("collision_total_dones", done_cnt[1] - d0, 1);

    // DATA_BITS=24 random message, gap-free then with din_valid gaps
    msg = 24'($urandom());
    c   = model_crc(msg, 24);
    run_frame(2, 24, msg, c, 1'b1, c, 0, 1'b1, lat0, gt);
    chk("latency_db24", lat0, 41);
    run_frame(2, 24, msg, c, 1'b1, c, 1, 1'b1, lat, gt);
    chk("latency_with_gaps", lat, lat0 + gt);

    // Abort at message bit 10, then a full correct frame
    d0 = done_cnt[2];
    step(2, 1'b1, 1'b0, 1'b0);
    for (int i = 23; i > 13; i--) step(2, 1'b0, 1'b1, msg[i]);
    run_frame(2, 24, msg, c, 1'b1, c, 0, 1'b1, lat, gt);
    chk("abort_latency", lat, 41);
    chk("abort_total_dones", done_cnt[2] - d0, 1);

    // Reset on CRC bit 5
    d0 = done_cnt[2];
    step(2, 1'b1, 1'b0, 1'b0);
    for (int i = 23; i >= 0; i--) step(2, 1'b0, 1'b1, msg[i]);
    for (int i = 15; i > 11; i--) step(2, 1'b0, 1'b1, c[i]);
    rst = 1'b1;
    step(2, 1'b0, 1'b1, c[11]);
    rst = 1'b0;
    chk("rst_busy", int'(busy_v[2]), 0);
    chk("rst_done", int'(done_v[2]), 0);
    chk("rst_crc_ok", int'(ok_v[2]), 0);
    chk("rst_calc", int'(calc_v[2]), 0);
    chk("rst_rx", int'(rx_v[2]), 0);
    chk("rst_bit_cnt", int'(cnt_v[2]), 0);
    for (int i = 10; i >= 0; i--) step(-1, 1'b0, 1'b1, c[i]);
    repeat (3) step(-1, 1'b0, 1'b0, 1'b0);
    chk("rst_no_done", done_cnt[2] - d0, 0);
    chk("rst_stays_idle", int'(busy_v[2]), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
